// File: rtl/bus_master.sv
// bus_master: sequencing initiator for the shared tri-state sysbus.
// Takes one memory request at a time on a valid/ready interface and turns it
// into the MAR/MDR load-and-drive sequence used by the ROM/RAM responders.
// Completion is reported on a one-cycle resp_valid strobe.
//
// Ports:
//   clock, reset          sole clock (rising edge), async active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_write             1 = write, 0 = read
//   req_addr [AW-1:0]     target address, MSB 0 = ROM, 1 = RAM
//   req_wdata             write data
//   resp_valid            one-cycle completion strobe
//   resp_rdata            read data, held until the next read completes
//   resp_err              request rejected (qualifies resp_valid)
//   load_MAR, load_MDR, MDR_bus, CS, R_NW   memory control strobes
//   sysbus                shared tri-state bus
//
// Build option: define BUS_MASTER_ROM_GUARD_EN to reject ROM-region writes
// with an error response instead of running a bus cycle.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a request, bus released
// ADDR    | address on sysbus, load_MAR
// WDATA   | write data on sysbus, load_MDR, R_NW=0
// WCOMMIT | CS with R_NW=0, memory takes MDR
// RFETCH  | CS with R_NW=1, memory loads MDR
// RDRIVE  | MDR_bus, read data sampled at the closing edge
// REJECT  | (guard build only) ROM write refused, no bus activity

module bus_master #(
   parameter int WORD_W = 8,
   parameter int OP_W   = 3
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [WORD_W-OP_W-1:0]   req_addr,
   input  logic [WORD_W-1:0]        req_wdata,
   output logic                     resp_valid,
   output logic [WORD_W-1:0]        resp_rdata,
   output logic                     resp_err,
   output logic                     load_MAR,
   output logic                     load_MDR,
   output logic                     MDR_bus,
   output logic                     CS,
   output logic                     R_NW,
   inout  wire  [WORD_W-1:0]        sysbus
);

   localparam int AW = WORD_W - OP_W;

`ifdef BUS_MASTER_ROM_GUARD_EN
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR    = 3'd1,
      WDATA   = 3'd2,
      WCOMMIT = 3'd3,
      RFETCH  = 3'd4,
      RDRIVE  = 3'd5,
      REJECT  = 3'd6
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR    = 3'd1,
      WDATA   = 3'd2,
      WCOMMIT = 3'd3,
      RFETCH  = 3'd4,
      RDRIVE  = 3'd5
   } state_t;
`endif

   state_t              state;
   state_t              state_next;
   logic [AW-1:0]       addr_q;
   logic [WORD_W-1:0]   wdata_q;
   logic                write_q;
   logic                bus_en;
   logic [WORD_W-1:0]   bus_out;
   logic                resp_done;
`ifdef BUS_MASTER_ROM_GUARD_EN
   logic                resp_rej;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
      end else if (state == IDLE && req_valid) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         write_q <= req_write;
      end
   end

   // All strobes come from the registered state only; req_* feed next state.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      load_MAR   = 1'b0;
      load_MDR   = 1'b0;
      MDR_bus    = 1'b0;
      CS         = 1'b0;
      R_NW       = 1'b1;
      bus_en     = 1'b0;
      bus_out    = '0;
      resp_done  = 1'b0;
`ifdef BUS_MASTER_ROM_GUARD_EN
      resp_rej   = 1'b0;
`endif
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
`ifdef BUS_MASTER_ROM_GUARD_EN
               if (req_write && !req_addr[AW-1]) state_next = REJECT;
               else                              state_next = ADDR;
`else
               state_next = ADDR;
`endif
            end
         end
         ADDR: begin
            bus_en     = 1'b1;
            bus_out    = {{OP_W{1'b0}}, addr_q};
            load_MAR   = 1'b1;
            state_next = write_q ? WDATA : RFETCH;
         end
         WDATA: begin
            bus_en     = 1'b1;
            bus_out    = wdata_q;
            load_MDR   = 1'b1;
            R_NW       = 1'b0;
            state_next = WCOMMIT;
         end
         WCOMMIT: begin
            CS         = 1'b1;
            R_NW       = 1'b0;
            resp_done  = 1'b1;
            state_next = IDLE;
         end
         RFETCH: begin
            CS         = 1'b1;
            load_MDR   = 1'b1;
            state_next = RDRIVE;
         end
         RDRIVE: begin
            MDR_bus    = 1'b1;
            resp_done  = 1'b1;
            state_next = IDLE;
         end
`ifdef BUS_MASTER_ROM_GUARD_EN
         REJECT: begin
            resp_done  = 1'b1;
            resp_rej   = 1'b1;
            state_next = IDLE;
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   assign sysbus = bus_en ? bus_out : {WORD_W{1'bz}};

   // resp_valid lands in the cycle after the last bus state, when the FSM
   // is already back in IDLE and can take the next request.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= resp_done;
         if (state == RDRIVE) resp_rdata <= sysbus;
      end
   end

`ifdef BUS_MASTER_ROM_GUARD_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) resp_err <= 1'b0;
      else       resp_err <= resp_rej;
   end
`else
   assign resp_err = 1'b0;
`endif

endmodule

// File: doc/bus_master.md
# bus_master

Sequencing initiator for the shared tri-state `sysbus` of the basic processor. It accepts one memory request at a time on a valid/ready interface and converts it into the MAR/MDR load-and-drive sequence that the ROM and RAM responders expect. It returns the read data or the write completion on a one-cycle response strobe. It sits between the datapath and the memories, and is the only block that asserts `load_MAR`, `load_MDR`, `MDR_bus`, `CS` and `R_NW`.

## Interface
- `WORD_W`, default 8: bus/data width.
- `OP_W`, default 3: opcode width. The address width is `AW = WORD_W-OP_W` (5). The address MSB selects the region: 0 = ROM, 1 = RAM.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request (IDLE only).
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  target address.
- `req_wdata`  in  WORD_W  write data.
- `resp_valid`  out  1  one-cycle completion strobe.
- `resp_rdata`  out  WORD_W  read data; holds until the next read completes.
- `resp_err`  out  1  qualifies `resp_valid`; the request was rejected (see Configuration).
- `load_MAR`, `load_MDR`, `MDR_bus`, `CS`, `R_NW`  out  1 each  memory control strobes.
- `sysbus`  inout  WORD_W  shared tri-state bus.

## Operation
- States: IDLE, ADDR, WDATA, WCOMMIT, RFETCH, RDRIVE.
- IDLE: `req_ready`=1. On an edge with `req_valid`=1, capture addr, wdata and write into internal registers and go to ADDR. The request inputs are ignored in every other state.
- ADDR: drive `sysbus`={OP_W'0, addr} with `load_MAR`=1. Next state is WDATA if write, otherwise RFETCH.
- WDATA: drive `sysbus`=wdata with `load_MDR`=1 and `R_NW`=0. Next state is WCOMMIT.
- WCOMMIT: `CS`=1, `R_NW`=0, bus released. Next state is IDLE and `resp_valid` is set.
- RFETCH: `CS`=1, `R_NW`=1, `load_MDR`=1, bus released. Next state is RDRIVE.
- RDRIVE: `MDR_bus`=1, `R_NW`=1. At the closing edge, register `sysbus` into `resp_rdata`, set `resp_valid`, and go to IDLE.
- `sysbus` is driven only in ADDR and WDATA and is 'z in every other state.
- All strobes are decoded from the registered state, so they are glitch-free with no combinational path from the `req_*` inputs.
- `R_NW` idles at 1.
- `resp_err`=0 whenever `resp_valid`=0.

## Timing
- A request accepted at edge 0 occupies states in cycles 1, 2 and 3. `resp_valid` is high in cycle 4 only.
- `req_ready` is high again in cycle 4, so a back-to-back request is accepted at the start of cycle 4 (edge 4). Throughput is 1 transaction per 4 cycles.
- Read data is the `sysbus` value sampled at the end of RDRIVE, which is edge 3.
- Reset (asynchronous, any state) forces the following immediately:
  - state IDLE;
  - `sysbus`='z;
  - `load_MAR`, `load_MDR`, `MDR_bus`, `CS` = 0;
  - `R_NW`=1;
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
- A transaction in flight when reset asserts is abandoned with no response. `req_ready`=1 during and after reset.
- `req_valid` asserted while `req_ready`=0 is not consumed. The requester holds it until it is accepted.

## Configuration
- `BUS_MASTER_ROM_GUARD_EN` defined: a write request whose address MSB is 0 (ROM region) is accepted in IDLE, but the block produces no bus cycle.
  - The block enters a single-cycle REJECT state.
  - `resp_valid`=1 and `resp_err`=1 in cycle 2.
  - `resp_rdata` is unchanged.
- `BUS_MASTER_ROM_GUARD_EN` undefined: the REJECT state does not exist, `resp_err` is tied to 0, and ROM-region writes run the normal write sequence.

## Test plan
- Reset mid-RFETCH: all strobes drop to 0 in the same cycle, `sysbus`='z, `R_NW`=1, and no `resp_valid` follows. The next request completes normally.
- Read addr 15 against a ROM model holding word 15 = 8'd14:
  - the ADDR cycle drives `sysbus`=8'h0F with `load_MAR`;
  - `resp_valid` appears in cycle 4 with `resp_rdata`=8'd14.
- Write addr 31, data 8'hA5, then read addr 31 against a RAM model:
  - the WDATA cycle drives 8'hA5 with `load_MDR` and `R_NW`=0;
  - the read returns 8'hA5.
- Back-to-back reads of addr 14 then addr 0, with `req_valid` held high: the second request is accepted at edge 4 and the responses arrive in cycles 4 and 8 with values 8'd5 and the ROM word at addr 0. `sysbus` is never driven by the master outside ADDR/WDATA.
- With `BUS_MASTER_ROM_GUARD_EN`, write addr 3:
  - no strobe is asserted;
  - `resp_valid`=`resp_err`=1 in cycle 2;
  - the following read of addr 15 still returns 8'd14.
- Without `BUS_MASTER_ROM_GUARD_EN`, repeat the addr-3 write: the full 3-state write sequence runs and `resp_err`=0.
